// File: rtl/morph3x3_stream_if.sv
// morph3x3_stream_if: pixel stream handshake bundle for morph3x3_stream
// Ports: in_valid/in_ready/in_data (pixel input channel),
//        out_valid/out_ready/out_data/out_last (pixel output channel).
// master = pixel source / sink side, slave = the filter.
interface morph3x3_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_last;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/morph3x3_stream.sv
// morph3x3_stream: streaming 3x3 morphology filter (boundary/erode/dilate/pass), two line buffers
// Ports: clk, rst_n (async active-low), mode/thr (sampled at first pixel of a frame),
//        s (stream interface: pixel in, pixel out with out_last), busy (frame in flight).
module morph3x3_stream #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int PIX_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [PIX_W-1:0]       thr,
  morph3x3_stream_if.slave       s,
  output logic                   busy
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT + 2);
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [XW-1:0]    ix_q, ix_d, ox_q, ox_d;
  logic [YW-1:0]    iy_q, iy_d, oy_q, oy_d;
  logic [1:0]       mode_q, mode_d;
  logic [PIX_W-1:0] thr_q, thr_d, out_data_q, out_data_d, res;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d;
  logic [PIX_W-1:0] lb0_q [WIDTH];
  logic [PIX_W-1:0] lb1_q [WIDTH];
  logic [PIX_W-1:0] w_q [9];
  logic [PIX_W-1:0] w_d [9];
  logic slot_free, in_fire, out_done, gen, adv, border, ix_end, ox_end, oy_last;
  logic any_dark, any_bright, all_bright;
  assign slot_free  = !out_valid_q || s.out_ready;
  assign s.in_ready = state_q == FILL || (state_q == STREAM && slot_free);
  assign in_fire    = s.in_valid && s.in_ready;
  assign out_done   = out_valid_q && s.out_ready && out_last_q;
  // In FLUSH the window keeps shifting with dummy columns so the centre still
  // walks through the real pixels of the last line (needed by pass mode).
  assign gen = (state_q == STREAM && in_fire) || (state_q == FLUSH && slot_free && !(out_valid_q && out_last_q));
  assign adv = in_fire || gen;
  assign ix_end  = ix_q == XW'(WIDTH - 1);
  assign ox_end  = ox_q == XW'(WIDTH - 1);
  assign oy_last = oy_q == YW'(HEIGHT - 1);
  assign border  = ox_q == '0 || ox_end || oy_q == '0 || oy_last;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign busy        = busy_q;
  // Right column of the shifted window: rows y-2, y-1, y at the input column,
  // so the centre w_d[4] is always pixel i-WIDTH-1 (the output centre).
  always_comb begin
    for (int j = 0; j < 9; j++) w_d[j] = w_q[j];
    if (adv) begin
      for (int r = 0; r < 3; r++) begin
        w_d[3*r]   = w_q[3*r+1];
        w_d[3*r+1] = w_q[3*r+2];
      end
      w_d[2] = lb1_q[ix_q];
      w_d[5] = lb0_q[ix_q];
      w_d[8] = s.in_data;
    end
  end
  always_comb begin
    any_dark   = 1'b0;
    any_bright = 1'b0;
    all_bright = 1'b1;
    for (int j = 0; j < 9; j++) begin
      any_dark   = any_dark || (j != 4 && w_d[j] < thr_q);
      any_bright = any_bright || w_d[j] > thr_q;
      all_bright = all_bright && w_d[j] > thr_q;
    end
    res = mode_q == 2'd3 ? w_d[4] :
          border         ? '0 :
          mode_q == 2'd0 ? ((w_d[4] > thr_q && any_dark) ? w_d[4] : '0) :
          mode_q == 2'd1 ? (all_bright ? w_d[4] : '0) :
                           (any_bright ? '1 : '0);
  end
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    busy_d      = busy_q;
    ix_d        = adv ? (ix_end ? '0 : ix_q + XW'(1)) : ix_q;
    iy_d        = adv && ix_end ? iy_q + YW'(1) : iy_q;
    ox_d        = gen ? (ox_end ? '0 : ox_q + XW'(1)) : ox_q;
    oy_d        = gen && ox_end ? oy_q + YW'(1) : oy_q;
    out_data_d  = gen ? res : out_data_q;
    out_valid_d = gen || (out_valid_q && !s.out_ready);
    out_last_d  = gen ? (ox_end && oy_last) : out_last_q && !s.out_ready;
    if (state_q == FILL && in_fire && ix_q == '0 && iy_q == '0) begin
      mode_d = mode;
      thr_d  = thr;
      busy_d = 1'b1;
    end
    if (state_q == FILL && in_fire && ix_q == '0 && iy_q == YW'(1)) state_d = STREAM;
    if (state_q == STREAM && in_fire && ix_end && iy_q == YW'(HEIGHT - 1)) state_d = FLUSH;
    if (state_q == FLUSH && out_done) begin
      state_d = FILL;
      busy_d  = 1'b0;
      ix_d    = '0;
      iy_d    = '0;
      ox_d    = '0;
      oy_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      ix_q        <= '0;
      iy_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < 9; j++) w_q[j] <= w_d[j];
    if (adv) begin
      lb1_q[ix_q] <= lb0_q[ix_q];
      lb0_q[ix_q] <= s.in_data;
    end
  end
endmodule

// File: tb/tb_morph3x3_stream.sv
// tb_morph3x3_stream: directed self-checking bench for morph3x3_stream (8x6 frames)
module tb_morph3x3_stream;
  logic       clk, rst_n, busy, rnd_rdy;
  logic [1:0] mode;
  logic [7:0] thr;
  logic [7:0] pix [48];
  logic [7:0] got_d [1024];
  logic       got_l [1024];
  int         in_cyc [1024];
  int         out_cyc [1024];
  int         n_in, n_out, cyc, n_cmp, n_bad;
  morph3x3_stream_if #(.PIX_W(8)) dif ();
  morph3x3_stream #(.WIDTH(8), .HEIGHT(6), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .thr(thr), .s(dif.slave), .busy(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end
  initial begin
    dif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dif.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial begin
    n_in = 0;
    n_out = 0;
    forever begin
      @(negedge clk);
      if (rst_n && dif.in_valid && dif.in_ready) begin
        in_cyc[n_in] = cyc;
        n_in = n_in + 1;
      end
      if (rst_n && dif.out_valid && dif.out_ready) begin
        got_d[n_out] = dif.out_data;
        got_l[n_out] = dif.out_last;
        out_cyc[n_out] = cyc;
        n_out = n_out + 1;
      end
    end
  end
  task automatic send(input int n);
    int sent, t;
    sent = 0;
    t = 0;
    while (sent < n && t < 3000) begin
      dif.in_valid = 1'b1;
      dif.in_data = pix[sent % 48];
      @(negedge clk);
      if (dif.in_ready) sent++;
      @(posedge clk);
      #1;
      t++;
    end
    dif.in_valid = 1'b0;
    if (sent < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout sent=%0d required=%0d", sent, n);
    end
  endtask
  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 4000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] v);
    for (int j = 0; j < 48; j++) pix[j] = v;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b required=0", dif.out_valid); end
    n_cmp++; if (dif.out_data !== 8'd0) begin n_bad++; $display("FAIL rst_out_data got=%0d required=0", dif.out_data); end
    n_cmp++; if (dif.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last got=%b required=0", dif.out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b required=0", busy); end
    n_cmp++; if (dif.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b required=1", dif.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_all_bright(input string nm);
    int b, ib;
    fill(8'd200);
    mode = 2'd0;
    thr = 8'd127;
    b = n_out;
    ib = n_in;
    send(48);
    wait_out(b + 48);
    n_cmp++; if (n_out - b !== 48) begin n_bad++; $display("FAIL %s_count got=%0d required=48", nm, n_out - b); end
    for (int k = 0; k < 48; k++) begin
      n_cmp++; if (got_d[b+k] !== 8'd0) begin n_bad++; $display("FAIL %s_data k=%0d got=%0d required=0", nm, k, got_d[b+k]); end
      n_cmp++; if (got_l[b+k] !== (k == 47)) begin n_bad++; $display("FAIL %s_last k=%0d got=%b required=%b", nm, k, got_l[b+k], k == 47); end
    end
    n_cmp++; if (out_cyc[b] !== in_cyc[ib+9] + 1) begin n_bad++; $display("FAIL %s_latency got=%0d required=%0d", nm, out_cyc[b], in_cyc[ib+9] + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end got=%b required=0", nm, busy); end
  endtask
  task automatic test_boundary_erode();
    int b, x, y, dx, dy;
    logic [7:0] e;
    fill(8'd200);
    pix[27] = 8'd10;
    thr = 8'd127;
    for (int m = 0; m < 2; m++) begin
      mode = 2'(m);
      b = n_out;
      send(48);
      wait_out(b + 48);
      n_cmp++; if (n_out - b !== 48) begin n_bad++; $display("FAIL s2_count m=%0d got=%0d required=48", m, n_out - b); end
      for (int k = 0; k < 48; k++) begin
        x = k % 8; y = k / 8; dx = x - 3; dy = y - 3;
        if (x == 0 || x == 7 || y == 0 || y == 5) e = 8'd0;
        else if (m == 0) e = (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1 && !(dx == 0 && dy == 0)) ? 8'd200 : 8'd0;
        else e = (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1) ? 8'd0 : 8'd200;
        n_cmp++; if (got_d[b+k] !== e) begin n_bad++; $display("FAIL s2_data m=%0d k=%0d got=%0d required=%0d", m, k, got_d[b+k], e); end
      end
    end
  endtask
  task automatic test_dilate_thr();
    int b, dx, dy;
    logic [7:0] e, v;
    mode = 2'd2;
    thr = 8'd127;
    for (int r = 0; r < 2; r++) begin
      v = r == 0 ? 8'd128 : 8'd127;
      fill(8'd0);
      pix[20] = v;
      b = n_out;
      send(48);
      wait_out(b + 48);
      n_cmp++; if (n_out - b !== 48) begin n_bad++; $display("FAIL s3_count v=%0d got=%0d required=48", v, n_out - b); end
      for (int k = 0; k < 48; k++) begin
        dx = k % 8 - 4; dy = k / 8 - 2;
        e = (r == 0 && dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1) ? 8'd255 : 8'd0;
        n_cmp++; if (got_d[b+k] !== e) begin n_bad++; $display("FAIL s3_data v=%0d k=%0d got=%0d required=%0d", v, k, got_d[b+k], e); end
      end
    end
  endtask
  task automatic test_pass_stall();
    int b;
    for (int j = 0; j < 48; j++) pix[j] = 8'($urandom_range(0, 255));
    mode = 2'd3;
    thr = 8'd127;
    b = n_out;
    rnd_rdy = 1'b1;
    fork
      send(48);
      begin : chk
        logic [7:0] pd;
        logic stalled;
        int t;
        stalled = 1'b0;
        pd = '0;
        t = 0;
        while (n_out < b + 48 && t < 4000) begin
          @(negedge clk);
          t++;
          if (stalled) begin
            n_cmp++;
            if (dif.out_valid !== 1'b1 || dif.out_data !== pd) begin n_bad++; $display("FAIL s4_hold got=%b/%0d required=1/%0d", dif.out_valid, dif.out_data, pd); end
          end
          if (dif.out_valid && !dif.out_ready) begin
            n_cmp++;
            if (dif.in_ready !== 1'b0) begin n_bad++; $display("FAIL s4_in_ready_stall got=%b required=0", dif.in_ready); end
          end
          stalled = dif.out_valid && !dif.out_ready;
          pd = dif.out_data;
        end
      end
    join
    wait_out(b + 48);
    rnd_rdy = 1'b0;
    n_cmp++; if (n_out - b !== 48) begin n_bad++; $display("FAIL s4_count got=%0d required=48", n_out - b); end
    for (int k = 0; k < 48; k++) begin
      n_cmp++; if (got_d[b+k] !== pix[k]) begin n_bad++; $display("FAIL s4_data k=%0d got=%0d required=%0d", k, got_d[b+k], pix[k]); end
      n_cmp++; if (got_l[b+k] !== (k == 47)) begin n_bad++; $display("FAIL s4_last k=%0d got=%b required=%b", k, got_l[b+k], k == 47); end
    end
  endtask
  task automatic test_mode_change();
    int b, ib, x, y, dx, dy, lasts;
    logic [7:0] e;
    fill(8'd200);
    pix[27] = 8'd10;
    mode = 2'd0;
    thr = 8'd127;
    b = n_out;
    ib = n_in;
    fork
      send(96);
      begin
        int t;
        t = 0;
        while (n_in < ib + 20 && t < 2000) begin @(posedge clk); #1; t++; end
        mode = 2'd1;
        thr = 8'd5;
      end
    join
    wait_out(b + 96);
    n_cmp++; if (n_out - b !== 96) begin n_bad++; $display("FAIL s5_count got=%0d required=96", n_out - b); end
    lasts = 0;
    for (int k = 0; k < 96; k++) begin
      x = k % 8; y = (k % 48) / 8; dx = x - 3; dy = y - 3;
      if (x == 0 || x == 7 || y == 0 || y == 5) e = 8'd0;
      else if (k < 48) e = (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1 && !(dx == 0 && dy == 0)) ? 8'd200 : 8'd0;
      else e = pix[k % 48];
      n_cmp++; if (got_d[b+k] !== e) begin n_bad++; $display("FAIL s5_data k=%0d got=%0d required=%0d", k, got_d[b+k], e); end
      if (got_l[b+k] === 1'b1) lasts++;
    end
    n_cmp++; if (lasts !== 2) begin n_bad++; $display("FAIL s5_last_pulses got=%0d required=2", lasts); end
    n_cmp++; if (got_l[b+47] !== 1'b1 || got_l[b+95] !== 1'b1) begin n_bad++; $display("FAIL s5_last_pos got=%b%b required=11", got_l[b+47], got_l[b+95]); end
    mode = 2'd0;
    thr = 8'd127;
  endtask
  task automatic test_abort();
    fill(8'd200);
    mode = 2'd0;
    thr = 8'd127;
    send(20);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL s6_abort_out_valid got=%b required=0", dif.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL s6_abort_busy got=%b required=0", busy); end
    n_cmp++; if (dif.in_ready !== 1'b1) begin n_bad++; $display("FAIL s6_abort_in_ready got=%b required=1", dif.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_all_bright("s6");
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rnd_rdy = 1'b0;
    mode = 2'd0;
    thr = 8'd127;
    dif.in_valid = 1'b0;
    dif.in_data = 8'd0;
    test_reset();
    test_all_bright("s1");
    test_boundary_erode();
    test_dilate_thr();
    test_pass_stall();
    test_mode_change();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
